// File: rtl/mops_pmt_integral.sv
// Per-PMT feeder for the MoPS trigger: slow baseline tracker frozen during pulses,
// plus a leaky integral of the baseline-subtracted signal, one update per 40 MHz sample.
module mops_pmt_integral #(
  parameter int ADC_WIDTH    = 12,
  parameter int INT_BITS     = 19,
  parameter int BL_FRAC      = 6,
  parameter int DECAY_SHIFT  = 6,
  parameter int HOLD_SAMPLES = 16,
  parameter int BL_RESET     = 256
) (
  input  logic                 CLK120,
  input  logic                 RESET_N,
  input  logic [1:0]           ENABLE40,
  input  logic [ADC_WIDTH-1:0] ADC,
  input  logic [ADC_WIDTH-1:0] FREEZE_THR,
  input  logic                 BL_LOAD,
  input  logic [ADC_WIDTH-1:0] BL_INIT,
  output logic [INT_BITS-1:0]  INTEGRAL,
  output logic [ADC_WIDTH-1:0] BASELINE,
  output logic                 TRACKING,
  output logic                 SATURATED
);

  localparam int ACC_W = ADC_WIDTH + BL_FRAC;
  localparam logic [ACC_W-1:0] ACC_MAX   = '1;
  localparam logic [ACC_W-1:0] ACC_RST   = ACC_W'(BL_RESET) << BL_FRAC;
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_SAMPLES);

  // Registered 40 MHz phase; every pipeline stage keys off this copy.
  typedef enum logic [1:0] {
    PH_SAMPLE = 2'd0,
    PH_DIFF   = 2'd1,
    PH_UPDATE = 2'd2,
    PH_IDLE   = 2'd3
  } phase_t;

  phase_t                 ph;
  logic [ADC_WIDTH-1:0]   adc_r;
  logic signed [ADC_WIDTH:0] diff;
  logic                   above;
  logic [7:0]             hold_cnt;
  logic [ACC_W-1:0]       bl_acc;
  logic [INT_BITS-1:0]    integral;
  logic                   saturated;
  logic                   tracking;

  logic [ADC_WIDTH-1:0]      bl_i;
  logic signed [ADC_WIDTH:0] diff_next;
  logic                      above_next;
  logic [INT_BITS-1:0]       decay;
  logic [ADC_WIDTH-1:0]      gain;
  logic [INT_BITS:0]         sum;
  logic [ACC_W-1:0]          bl_acc_next;

  assign bl_i = bl_acc[ACC_W-1:BL_FRAC];

  always_comb begin
    diff_next  = $signed({1'b0, adc_r}) - $signed({1'b0, bl_i});
    // Compared one bit wider so a large threshold cannot wrap around.
    above_next = {1'b0, adc_r} > ({1'b0, bl_i} + {1'b0, FREEZE_THR});

    decay = integral >> DECAY_SHIFT;
    if (decay == '0 && integral != '0) begin
      decay = INT_BITS'(1);
    end

    gain = '0;
    if (!diff[ADC_WIDTH] && diff != '0) begin
      gain = diff[ADC_WIDTH-1:0];
    end

    sum = {1'b0, integral} - {1'b0, decay}
        + {{(INT_BITS + 1 - ADC_WIDTH){1'b0}}, gain};

    bl_acc_next = bl_acc;
    if (!diff[ADC_WIDTH] && diff != '0 && bl_acc != ACC_MAX) begin
      bl_acc_next = bl_acc + ACC_W'(1);
    end else if (diff[ADC_WIDTH] && bl_acc != '0) begin
      bl_acc_next = bl_acc - ACC_W'(1);
    end
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      ph    <= PH_SAMPLE;
      adc_r <= '0;
      diff  <= '0;
      above <= 1'b0;
    end else begin
      ph <= phase_t'(ENABLE40);
      if (ph == PH_SAMPLE) begin
        adc_r <= ADC;
      end
      if (ph == PH_DIFF) begin
        diff  <= diff_next;
        above <= above_next;
      end
    end
  end

  // BL_LOAD wins over a coincident update; that sample's result is discarded.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      integral  <= '0;
      saturated <= 1'b0;
    end else if (BL_LOAD) begin
      integral  <= '0;
      saturated <= 1'b0;
    end else if (ph == PH_UPDATE) begin
      if (sum[INT_BITS]) begin
        integral  <= '1;
        saturated <= 1'b1;
      end else begin
        integral  <= sum[INT_BITS-1:0];
        saturated <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      bl_acc   <= ACC_RST;
      hold_cnt <= '0;
      tracking <= 1'b0;
    end else if (BL_LOAD) begin
      bl_acc   <= {BL_INIT, {BL_FRAC{1'b0}}};
      hold_cnt <= '0;
    end else if (ph == PH_UPDATE) begin
      tracking <= !above && hold_cnt == '0;
      if (above) begin
        hold_cnt <= HOLD_INIT;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end else begin
        bl_acc <= bl_acc_next;
      end
    end
  end

  assign INTEGRAL  = integral;
  assign BASELINE  = bl_i;
  assign TRACKING  = tracking;
  assign SATURATED = saturated;

endmodule

// File: tb/tb_mops_pmt_integral.sv
// Bench for mops_pmt_integral: three instances (default, slow leak, zero hold)
// checked against a per-sample arithmetic model plus hand-derived vectors.
module tb_mops_pmt_integral;

  localparam int NDUT    = 3;
  localparam int INT_MAX = 524287;
  localparam int ACC_MAX = 262143;

  logic        CLK120;
  logic        RESET_N;
  logic [1:0]  ENABLE40;
  logic [11:0] ADC;
  logic [11:0] FREEZE_THR;
  logic        BL_LOAD;
  logic [11:0] BL_INIT;

  logic [18:0] integ_o [NDUT];
  logic [11:0] bl_o    [NDUT];
  logic        trk_o   [NDUT];
  logic        sat_o   [NDUT];

  mops_pmt_integral dut0 (
    .CLK120(CLK120), .RESET_N(RESET_N), .ENABLE40(ENABLE40), .ADC(ADC),
    .FREEZE_THR(FREEZE_THR), .BL_LOAD(BL_LOAD), .BL_INIT(BL_INIT),
    .INTEGRAL(integ_o[0]), .BASELINE(bl_o[0]), .TRACKING(trk_o[0]), .SATURATED(sat_o[0])
  );

  mops_pmt_integral #(.DECAY_SHIFT(8)) dut1 (
    .CLK120(CLK120), .RESET_N(RESET_N), .ENABLE40(ENABLE40), .ADC(ADC),
    .FREEZE_THR(FREEZE_THR), .BL_LOAD(BL_LOAD), .BL_INIT(BL_INIT),
    .INTEGRAL(integ_o[1]), .BASELINE(bl_o[1]), .TRACKING(trk_o[1]), .SATURATED(sat_o[1])
  );

  mops_pmt_integral #(.HOLD_SAMPLES(0)) dut2 (
    .CLK120(CLK120), .RESET_N(RESET_N), .ENABLE40(ENABLE40), .ADC(ADC),
    .FREEZE_THR(FREEZE_THR), .BL_LOAD(BL_LOAD), .BL_INIT(BL_INIT),
    .INTEGRAL(integ_o[2]), .BASELINE(bl_o[2]), .TRACKING(trk_o[2]), .SATURATED(sat_o[2])
  );

  // clock / reset
  initial begin
    CLK120 = 1'b0;
    forever #5 CLK120 = ~CLK120;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1);
  end

  // reference model: one call per complete 40 MHz sample
  typedef struct {
    int acc;
    int integ;
    int hold;
    bit trk;
    bit sat;
  } mstate_t;

  typedef struct {
    int adc;
    int exp_int;
    int exp_bl;
    bit exp_trk;
  } vec_t;

  mstate_t mdl [NDUT];
  int      shift_p [NDUT] = '{6, 8, 6};
  int      hold_p  [NDUT] = '{16, 16, 0};
  int      total = 0;
  int      bad   = 0;
  bit      pending = 0;
  int      cur_thr = 20;

  function automatic mstate_t model_step(mstate_t s, int adc, int thr, int shift, int holdn);
    int bl, diff, d, sum;
    bit above;
    bl    = s.acc / 64;
    diff  = adc - bl;
    above = adc > bl + thr;
    d = s.integ / (1 << shift);
    if (d == 0 && s.integ != 0) d = 1;
    sum = s.integ - d + ((diff > 0) ? diff : 0);
    if (sum > INT_MAX) begin
      s.integ = INT_MAX;
      s.sat   = 1;
    end else begin
      s.integ = sum;
      s.sat   = 0;
    end
    s.trk = !above && s.hold == 0;
    if (above) s.hold = holdn;
    else if (s.hold > 0) s.hold = s.hold - 1;
    else if (diff > 0 && s.acc < ACC_MAX) s.acc = s.acc + 1;
    else if (diff < 0 && s.acc > 0) s.acc = s.acc - 1;
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NDUT; i++) begin
      mdl[i].acc = 256 * 64;
      mdl[i].integ = 0;
      mdl[i].hold = 0;
      mdl[i].trk = 0;
      mdl[i].sat = 0;
    end
  endfunction

  function automatic void model_load(int init);
    for (int i = 0; i < NDUT; i++) begin
      mdl[i].acc = init * 64;
      mdl[i].integ = 0;
      mdl[i].hold = 0;
      mdl[i].sat = 0;
    end
  endfunction

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_models(input string name);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("%s dut%0d integral", name, i), int'(integ_o[i]), mdl[i].integ);
      chk($sformatf("%s dut%0d baseline", name, i), int'(bl_o[i]), mdl[i].acc / 64);
      chk($sformatf("%s dut%0d tracking", name, i), int'(trk_o[i]), int'(mdl[i].trk));
      chk($sformatf("%s dut%0d saturated", name, i), int'(sat_o[i]), int'(mdl[i].sat));
    end
  endtask

  // drivers: inputs change 1 ns after the edge, outputs are read there too
  task automatic drive_phase(input logic [1:0] en);
    ENABLE40 = en;
    @(posedge CLK120);
    #1;
  endtask

  task automatic do_sample(input int adc, input int thr);
    ADC = 12'(adc);
    FREEZE_THR = 12'(thr);
    drive_phase(2'd0);
    if (pending) check_models("sample");
    pending = 0;
    drive_phase(2'd1);
    drive_phase(2'd2);
    for (int i = 0; i < NDUT; i++) mdl[i] = model_step(mdl[i], adc, thr, shift_p[i], hold_p[i]);
    pending = 1;
  endtask

  task automatic flush();
    drive_phase(2'd3);
    if (pending) check_models("flush");
    pending = 0;
  endtask

  task automatic bl_load(input int init);
    flush();
    BL_INIT = 12'(init);
    BL_LOAD = 1'b1;
    drive_phase(2'd3);
    BL_LOAD = 1'b0;
    model_load(init);
    check_models("bl_load");
  endtask

  vec_t vecs [6];

  initial begin
    int n_frozen, n_frozen_h0, bl_seen, adc, thr, r, base;

    vecs[0] = '{250,  0,    250, 1'b1};
    vecs[1] = '{1250, 1000, 250, 1'b0};
    vecs[2] = '{250,  985,  250, 1'b0};
    vecs[3] = '{260,  980,  250, 1'b0};
    vecs[4] = '{240,  965,  250, 1'b0};
    vecs[5] = '{4095, 4795, 250, 1'b0};

    RESET_N = 1'b0;
    ENABLE40 = 2'd3;
    ADC = '0;
    FREEZE_THR = '0;
    BL_LOAD = 1'b0;
    BL_INIT = '0;
    model_reset();
    repeat (3) @(posedge CLK120);
    #1;
    check_models("reset");
    @(negedge CLK120);
    RESET_N = 1'b1;

    // flat input at the loaded baseline
    bl_load(250);
    repeat (1000) do_sample(250, 20);
    flush();
    chk("flat integral", int'(integ_o[0]), 0);
    chk("flat tracking", int'(trk_o[0]), 1);

    // baseline converging from 200 to 210
    bl_load(200);
    do_sample(210, 20);
    flush();
    chk("conv first integral", int'(integ_o[0]), 10);
    repeat (63) do_sample(210, 20);
    flush();
    chk("conv baseline after 64", int'(bl_o[0]), 201);
    repeat (1500) do_sample(210, 20);
    flush();
    chk("conv final baseline", int'(bl_o[0]), 210);
    chk("conv final integral", int'(integ_o[0]), 0);

    // four-sample pulse freezes the tracker
    bl_load(250);
    repeat (3) do_sample(250, 20);
    flush();
    n_frozen = 0;
    n_frozen_h0 = 0;
    bl_seen = 250;
    for (int k = 0; k < 34; k++) begin
      do_sample((k < 4) ? 1000 : 250, 20);
      flush();
      if (!trk_o[0]) n_frozen++;
      if (!trk_o[2]) n_frozen_h0++;
      if (int'(bl_o[0]) != 250) bl_seen = int'(bl_o[0]);
      if (k == 3) chk("pulse peak", int'(integ_o[0]), 2932);
    end
    chk("pulse frozen samples", n_frozen, 20);
    chk("pulse frozen samples hold0", n_frozen_h0, 4);
    chk("pulse baseline held", bl_seen, 250);
    repeat (500) do_sample(250, 20);
    flush();
    chk("pulse integral back to zero", int'(integ_o[0]), 0);

    // hand-derived vectors
    bl_load(250);
    foreach (vecs[v]) begin
      do_sample(vecs[v].adc, 20);
      flush();
      chk($sformatf("vec%0d integral", v), int'(integ_o[0]), vecs[v].exp_int);
      chk($sformatf("vec%0d baseline", v), int'(bl_o[0]), vecs[v].exp_bl);
      chk($sformatf("vec%0d tracking", v), int'(trk_o[0]), int'(vecs[v].exp_trk));
    end

    // saturation on the slow-leak instance
    bl_load(0);
    repeat (300) do_sample(4095, 4095);
    flush();
    chk("sat integral", int'(integ_o[1]), INT_MAX);
    chk("sat flag", int'(sat_o[1]), 1);
    repeat (20) do_sample(4095, 4095);
    flush();
    chk("sat integral held", int'(integ_o[1]), INT_MAX);
    do_sample(0, 4095);
    flush();
    chk("sat release flag", int'(sat_o[1]), 0);
    chk("sat release integral", int'(integ_o[1]), INT_MAX - 2047);

    // latency: phase-0 edge to INTEGRAL is three edges
    bl_load(250);
    repeat (5) do_sample(250, 20);
    flush();
    ADC = 12'd1250;
    FREEZE_THR = 12'd20;
    drive_phase(2'd0);
    drive_phase(2'd1);
    chk("latency edge1", int'(integ_o[0]), 0);
    ADC = 12'd1250;
    drive_phase(2'd2);
    chk("latency edge2", int'(integ_o[0]), 0);
    ADC = 12'd250;
    drive_phase(2'd0);
    chk("latency edge3", int'(integ_o[0]), 1000);
    for (int i = 0; i < NDUT; i++) mdl[i] = model_step(mdl[i], 1250, 20, shift_p[i], hold_p[i]);
    repeat (10) drive_phase(2'd3);
    check_models("idle");

    // async reset mid-sample
    do_sample(1250, 20);
    flush();
    ADC = 12'd1250;
    drive_phase(2'd0);
    drive_phase(2'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_models("async reset");
    ENABLE40 = 2'd3;
    repeat (2) @(posedge CLK120);
    @(negedge CLK120);
    RESET_N = 1'b1;
    repeat (4) do_sample(300, 20);
    flush();

    // BL_LOAD coincident with the update edge
    bl_load(250);
    do_sample(1250, 20);
    flush();
    ADC = 12'd1250;
    drive_phase(2'd0);
    drive_phase(2'd1);
    drive_phase(2'd2);
    BL_INIT = 12'd300;
    BL_LOAD = 1'b1;
    drive_phase(2'd3);
    BL_LOAD = 1'b0;
    model_load(300);
    chk("load-on-update integral", int'(integ_o[0]), 0);
    chk("load-on-update baseline", int'(bl_o[0]), 300);
    chk("load-on-update saturated", int'(sat_o[0]), 0);
    repeat (5) do_sample(310, 20);
    flush();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        bl_load($urandom_range(0, 4095));
      end else if (r < 8) begin
        flush();
      end else begin
        base = mdl[0].acc / 64;
        if ($urandom_range(0, 4) == 0) adc = $urandom_range(0, 4095);
        else adc = base + $urandom_range(0, 20) - 10;
        if (adc < 0) adc = 0;
        if (adc > 4095) adc = 4095;
        thr = ($urandom_range(0, 9) == 0) ? 4095 : $urandom_range(0, 100);
        cur_thr = thr;
        do_sample(adc, thr);
      end
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
